// File: rtl/subtractor.sv
// Registered ripple-borrow subtractor: {co, y} = a - b - ci, with a signed-overflow flag.
// One cycle of latency; out_valid qualifies each captured result.
module subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             in_valid,
  output logic             co,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             ovf
);

  logic [WIDTH-1:0] y_d, y_q;
  logic             co_d, co_q;
  logic             ovf_d, ovf_q;
  logic             vld_q;
  logic             borrow;

  // Borrow ripples LSB to MSB through identical full-subtractor cells.
  always_comb begin
    y_d    = '0;
    borrow = ci;
    for (int i = 0; i < WIDTH; i++) begin
      y_d[i] = a[i] ^ b[i] ^ borrow;
      borrow = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
    end
    co_d  = borrow;
    ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (y_d[WIDTH-1] != a[WIDTH-1]);
  end

  // Result registers load only on valid input, so operands on idle cycles never reach them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        y_q   <= y_d;
        co_q  <= co_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign y         = y_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_subtractor.sv
// Directed and random checks of subtractor at WIDTH = 1, 8 and 32.
// Outputs are compared as {out_valid, co, ovf, y} one time unit after each rising edge.
module tb_subtractor;

  logic clk;
  logic rst_n;

  logic        a1, b1, ci1, iv1;
  logic        co1, y1, ov1, ovf1;
  logic [7:0]  a8, b8, y8;
  logic        ci8, iv8, co8, ov8, ovf8;
  logic [31:0] a32, b32, y32;
  logic        ci32, iv32, co32, ov32, ovf32;

  int checks;
  int failures;

  subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .ci(ci1), .in_valid(iv1),
    .co(co1), .y(y1), .out_valid(ov1), .ovf(ovf1)
  );

  subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci8), .in_valid(iv8),
    .co(co8), .y(y8), .out_valid(ov8), .ovf(ovf8)
  );

  subtractor #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .ci(ci32), .in_valid(iv32),
    .co(co32), .y(y32), .out_valid(ov32), .ovf(ovf32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0]  exp1;
    logic [10:0] exp8;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom); iv1 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); iv8 = 1'b1;
      a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom); iv32 = 1'b1;
      tick();
      checks++;
      if ({ov1, co1, ovf1, y1} !== 4'b0) begin
        failures++;
        $display("FAIL reset_hold_w1 got=%b want=0000", {ov1, co1, ovf1, y1});
      end
      checks++;
      if ({ov8, co8, ovf8, y8} !== 11'b0) begin
        failures++;
        $display("FAIL reset_hold_w8 got=%h want=000", {ov8, co8, ovf8, y8});
      end
      checks++;
      if ({ov32, co32, ovf32, y32} !== 35'b0) begin
        failures++;
        $display("FAIL reset_hold_w32 got=%h want=0", {ov32, co32, ovf32, y32});
      end
    end
    // First capture after release: 0x00 - 0x01 on W8, 1 - 0 on W1
    rst_n = 1'b1;
    a8 = 8'h00; b8 = 8'h01; ci8 = 1'b0; iv8 = 1'b1;
    a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0; iv1 = 1'b1;
    tick();
    exp8 = {1'b1, 1'b1, 1'b0, 8'hFF};
    checks++;
    if ({ov8, co8, ovf8, y8} !== exp8) begin
      failures++;
      $display("FAIL first_capture_w8 got=%h want=%h", {ov8, co8, ovf8, y8}, exp8);
    end
    exp1 = 4'b1001;
    checks++;
    if ({ov1, co1, ovf1, y1} !== exp1) begin
      failures++;
      $display("FAIL first_capture_w1 got=%b want=%b", {ov1, co1, ovf1, y1}, exp1);
    end
    // Reset asserted mid-cycle must clear outputs before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov8, co8, ovf8, y8} !== 11'b0) begin
      failures++;
      $display("FAIL async_reset_w8 got=%h want=000", {ov8, co8, ovf8, y8});
    end
    checks++;
    if ({ov1, co1, ovf1, y1} !== 4'b0) begin
      failures++;
      $display("FAIL async_reset_w1 got=%b want=0000", {ov1, co1, ovf1, y1});
    end
    #2;
    rst_n = 1'b1;
    iv1 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
    tick();
  endtask

  task automatic test_truth_table();
    logic [1:0] tt [8];
    logic [2:0] v;
    tt = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      {a1, b1, ci1} = v;
      iv1 = 1'b1;
      tick();
      checks++;
      if ({ov1, co1, y1} !== {1'b1, tt[k]}) begin
        failures++;
        $display("FAIL truth_table_%0d got=%b want=%b", k, {ov1, co1, y1}, {1'b1, tt[k]});
      end
    end
    iv1 = 1'b0;
  endtask

  task automatic test_w8_vectors();
    // a, b, ci, expected {co, ovf, y}
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vc [4];
    logic [9:0] ve [4];
    va = '{8'h00, 8'h50, 8'h80, 8'h7F};
    vb = '{8'h00, 8'h30, 8'h01, 8'hFF};
    vc = '{1'b1, 1'b0, 1'b0, 1'b0};
    ve = '{{2'b10, 8'hFF}, {2'b00, 8'h20}, {2'b01, 8'h7F}, {2'b11, 8'h80}};
    for (int k = 0; k < 4; k++) begin
      a8 = va[k]; b8 = vb[k]; ci8 = vc[k]; iv8 = 1'b1;
      tick();
      checks++;
      if ({ov8, co8, ovf8, y8} !== {1'b1, ve[k]}) begin
        failures++;
        $display("FAIL w8_vector_%0d got=%h want=%h", k, {ov8, co8, ovf8, y8}, {1'b1, ve[k]});
      end
    end
    iv8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [9:0] ve [3];
    va = '{8'h10, 8'h05, 8'h80};
    vb = '{8'h01, 8'h07, 8'h01};
    ve = '{{2'b00, 8'h0F}, {2'b10, 8'hFE}, {2'b01, 8'h7F}};
    for (int k = 0; k < 3; k++) begin
      a8 = va[k]; b8 = vb[k]; ci8 = 1'b0; iv8 = 1'b1;
      tick();
      checks++;
      if ({ov8, co8, ovf8, y8} !== {1'b1, ve[k]}) begin
        failures++;
        $display("FAIL b2b_valid_%0d got=%h want=%h", k, {ov8, co8, ovf8, y8}, {1'b1, ve[k]});
      end
    end
    for (int k = 0; k < 3; k++) begin
      iv8 = 1'b0;
      if (k == 0) begin
        a8 = 'x; b8 = 'x; ci8 = 1'bx;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      end
      tick();
      checks++;
      if ({ov8, co8, ovf8, y8} !== {1'b0, 2'b01, 8'h7F}) begin
        failures++;
        $display("FAIL b2b_hold_%0d got=%h want=%h", k, {ov8, co8, ovf8, y8}, {1'b0, 2'b01, 8'h7F});
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  r1;
    logic [8:0]  r8;
    logic [32:0] r32;
    logic [3:0]  e1;
    logic [10:0] e8;
    logic [34:0] e32;
    e1 = '0; e8 = '0; e32 = '0;
    for (int k = 0; k < 10000; k++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom);
      iv1 = (k == 0) ? 1'b1 : 1'($urandom);
      iv8 = (k == 0) ? 1'b1 : 1'($urandom);
      iv32 = (k == 0) ? 1'b1 : 1'($urandom);
      r1 = {1'b0, a1} - {1'b0, b1} - 2'(ci1);
      r8 = {1'b0, a8} - {1'b0, b8} - 9'(ci8);
      r32 = {1'b0, a32} - {1'b0, b32} - 33'(ci32);
      e1[3] = iv1;
      if (iv1) e1[2:0] = {r1[1], (a1 != b1) && (r1[0] != a1), r1[0]};
      e8[10] = iv8;
      if (iv8) e8[9:0] = {r8[8], (a8[7] != b8[7]) && (r8[7] != a8[7]), r8[7:0]};
      e32[34] = iv32;
      if (iv32) e32[33:0] = {r32[32], (a32[31] != b32[31]) && (r32[31] != a32[31]), r32[31:0]};
      tick();
      checks++;
      if ({ov1, co1, ovf1, y1} !== e1) begin
        failures++;
        $display("FAIL rand_w1_%0d got=%b want=%b", k, {ov1, co1, ovf1, y1}, e1);
      end
      checks++;
      if ({ov8, co8, ovf8, y8} !== e8) begin
        failures++;
        $display("FAIL rand_w8_%0d got=%h want=%h", k, {ov8, co8, ovf8, y8}, e8);
      end
      checks++;
      if ({ov32, co32, ovf32, y32} !== e32) begin
        failures++;
        $display("FAIL rand_w32_%0d got=%h want=%h", k, {ov32, co32, ovf32, y32}, e32);
      end
    end
    iv1 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0; iv1 = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0; iv8 = 1'b0;
    a32 = '0; b32 = '0; ci32 = 1'b0; iv32 = 1'b0;
    #1;
    test_reset();
    test_truth_table();
    test_w8_vectors();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
